pack24_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 24-to-128 width packer between N_SRC 24-bit requesters.
- Grants are given only on 384-bit frame boundaries (16 input beats = 3 packer output words). Each 128-bit output word therefore always carries data from exactly one source.
- Sits directly in front of the packer and drives the packer's valid_in/data_in.
- Reports the owner of the frame in flight.

---
 rtl/pack24_pkg.sv | 17 +
 rtl/rr_pick.sv | 25 ++
 rtl/pack24_rr_sched.sv | 112 +++++++++++
 tb/tb_pack24_rr_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pack24_pkg.sv
// pack24_pkg: shared widths, FSM encodings and owner-width helper for pack24_rr_sched.
package pack24_pkg;

    localparam int DATA_IN_W       = 24;
    localparam int DATA_OUT_W      = 128;
    localparam int BEATS_PER_FRAME = 16;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t BURST = 1'b1;

    function automatic int owner_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin first-set search of req starting at ptr, wrapping at N-1 -> 0.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        logic [W-1:0] j;
        idx = '0;
        j   = '0;
        // Walk the wrapped distance downward so the nearest requester wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
    end

    assign any = |req;

endmodule

// File: rtl/pack24_rr_sched.sv
// pack24_rr_sched: frame-granular round-robin feeder for a shared 24-to-128 packer.
// Optional pad-on-stall behaviour is enabled by defining PACK_PAD_EN.
module pack24_rr_sched
    import pack24_pkg::*;
#(
    parameter int N_SRC           = 2,
    parameter int BEATS_PER_FRAME = pack24_pkg::BEATS_PER_FRAME,
    parameter int IDLE_LIMIT      = 8,
    parameter int OW              = owner_w(N_SRC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_req,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [DATA_IN_W*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]           src_ready,
    output logic                       pk_valid,
    output logic [DATA_IN_W-1:0]       pk_data,
    output logic [OW-1:0]              pk_owner,
    output logic                       frame_done,
    output logic                       pad_err
);

    localparam int CW = $clog2(BEATS_PER_FRAME);

    state_t                state;
    logic [OW-1:0]         grant;
    logic [OW-1:0]         rr_ptr;
    logic [OW-1:0]         pick_idx;
    logic                  pick_any;
    logic [CW-1:0]         beat_cnt;
    logic [DATA_IN_W-1:0]  beat_data;
    logic                  pad_mode;
    logic                  accept;
    logic                  beat;
    logic                  last;

    rr_pick #(
        .N (N_SRC),
        .W (OW)
    ) u_pick (
        .req (src_req),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef PACK_PAD_EN
    localparam int SW = $clog2(IDLE_LIMIT + 1);

    logic [SW-1:0] stall_cnt;
    logic          pad_flag;

    assign pad_mode = (state == BURST) && (stall_cnt == SW'(IDLE_LIMIT));
    assign pad_err  = pad_flag;

    // Saturates at IDLE_LIMIT so pad mode persists until the frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            pad_flag  <= 1'b0;
        end else begin
            if (state != BURST || accept)
                stall_cnt <= '0;
            else if (!pad_mode)
                stall_cnt <= stall_cnt + 1'b1;
            if (pad_mode)
                pad_flag <= 1'b1;
        end
    end
`else
    assign pad_mode = 1'b0;
    assign pad_err  = 1'b0;
`endif

    assign src_ready = (state == BURST && !pad_mode) ? (N_SRC'(1) << grant) : '0;
    assign accept    = |(src_valid & src_ready);
    assign beat_data = src_data[DATA_IN_W*int'(grant) +: DATA_IN_W];
    assign beat      = accept || pad_mode;
    assign last      = beat && (beat_cnt == CW'(BEATS_PER_FRAME - 1));
    assign pk_owner  = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            pk_valid   <= 1'b0;
            pk_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            pk_valid   <= beat;
            frame_done <= last;
            if (beat)
                pk_data <= pad_mode ? '0 : beat_data;
            if (state == IDLE) begin
                if (pick_any) begin
                    state <= BURST;
                    grant <= pick_idx;
                end
            end else if (last) begin
                state    <= IDLE;
                beat_cnt <= '0;
                rr_ptr   <= (grant == OW'(N_SRC - 1)) ? '0 : grant + 1'b1;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pack24_rr_sched.sv
// tb_pack24_rr_sched: directed and random stimulus against a frame-level reference of the scheduler.
module tb_pack24_rr_sched;

    localparam int N   = 2;
    localparam int BPF = 16;
    localparam int LIM = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  src_req;
    logic [N-1:0]  src_valid;
    logic [47:0]   src_data;
    logic [N-1:0]  src_ready;
    logic          pk_valid;
    logic [23:0]   pk_data;
    logic [0:0]    pk_owner;
    logic          frame_done;
    logic          pad_err;

    pack24_rr_sched #(
        .N_SRC           (N),
        .BEATS_PER_FRAME (BPF),
        .IDLE_LIMIT      (LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_req    (src_req),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .pk_valid   (pk_valid),
        .pk_data    (pk_data),
        .pk_owner   (pk_owner),
        .frame_done (frame_done),
        .pad_err    (pad_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_pass;
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    int          m_stall;
    logic [23:0] m_data;
    bit          m_valid;
    bit          m_done;
    bit          m_perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_stall = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_perr  = 1'b0;
    endtask

    // One clock: check last edge's outputs, apply inputs, check src_ready, advance the frame model.
    task automatic cycle(input logic [1:0] req, input logic [1:0] vld, input logic [47:0] data);
        logic [1:0] exp_rdy;
        bit         pad;
        bit         found;
        @(negedge clk);
        chk("pk_valid", pk_valid, m_valid);
        chk("pk_data", pk_data, m_data);
        chk("frame_done", frame_done, m_done);
        chk("pk_owner", pk_owner, m_owner);
        chk("pad_err", pad_err, m_perr);
        src_req   = req;
        src_valid = vld;
        src_data  = data;
        #1;
`ifdef PACK_PAD_EN
        pad = m_busy && (m_stall == LIM);
`else
        pad = 1'b0;
`endif
        exp_rdy = (m_busy && !pad) ? 2'(1 << m_owner) : 2'b00;
        chk("src_ready", src_ready, exp_rdy);
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    found   = 1'b1;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_stall = 0;
            end
        end else if (pad || vld[m_owner]) begin
            m_valid = 1'b1;
            m_data  = pad ? 24'h0 : data[24*m_owner +: 24];
            m_cnt++;
            if (pad) m_perr = 1'b1;
            else m_stall = 0;
            if (m_cnt == BPF) begin
                m_done = 1'b1;
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else begin
            m_stall++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        src_req   = '0;
        src_valid = '0;
        src_data  = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #2;
        chk("rst_pk_valid", pk_valid, 1'b0);
        chk("rst_pk_data", pk_data, 24'h0);
        chk("rst_pk_owner", pk_owner, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_pad_err", pad_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single source, back-to-back beats 1..16
        cycle(2'b01, 2'b00, '0);
        for (int i = 1; i <= 16; i++)
            cycle(2'b01, 2'b01, {24'hABCDEF, 24'(i)});
        cycle(2'b00, 2'b00, '0);

        // fairness with both sources always requesting and valid
        for (int i = 0; i < 70; i++)
            cycle(2'b11, 2'b11, 48'({$urandom, $urandom}));
        for (int i = 0; i < 20; i++)
            cycle(2'b00, 2'b11, 48'({$urandom, $urandom}));

        // gaps on src1 while src0 is valid but not granted
        cycle(2'b10, 2'b00, '0);
        for (int i = 0; i < 31; i++)
            cycle(2'b10, (i % 2 == 0) ? 2'b11 : 2'b01, 48'({$urandom, $urandom}));
        cycle(2'b00, 2'b00, '0);

        // request withdrawn after grant
        cycle(2'b01, 2'b00, '0);
        for (int i = 0; i < 16; i++)
            cycle(2'b00, 2'b01, 48'({$urandom, $urandom}));
        cycle(2'b00, 2'b00, '0);

`ifdef PACK_PAD_EN
        // src0 stalls after 5 beats; src1 waits for the next frame
        cycle(2'b01, 2'b00, '0);
        for (int i = 0; i < 5; i++)
            cycle(2'b01, 2'b01, 48'({$urandom, $urandom}));
        for (int i = 0; i < 21; i++)
            cycle(2'b10, 2'b00, 48'({$urandom, $urandom}));
        for (int i = 0; i < 18; i++)
            cycle(2'b00, 2'b10, 48'({$urandom, $urandom}));
`endif

        for (int i = 0; i < 600; i++)
            cycle(2'($urandom), 2'($urandom), 48'({$urandom, $urandom}));
        for (int i = 0; i < 40; i++)
            cycle(2'b00, 2'b11, 48'({$urandom, $urandom}));

        // reset in the middle of a frame
        cycle(2'b01, 2'b00, '0);
        for (int i = 0; i < 7; i++)
            cycle(2'b01, 2'b01, {24'h0, 24'(i + 24'h100)});
        @(negedge clk);
        src_req   = '0;
        src_valid = '0;
        src_data  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_pk_valid", pk_valid, 1'b0);
        chk("async_pk_data", pk_data, 24'h0);
        chk("async_pk_owner", pk_owner, 1'b0);
        chk("async_frame_done", frame_done, 1'b0);
        chk("async_pad_err", pad_err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(2'b10, 2'b00, '0);
        for (int i = 0; i < 16; i++)
            cycle(2'b10, 2'b10, 48'({$urandom, $urandom}));
        cycle(2'b00, 2'b00, '0);
        cycle(2'b00, 2'b00, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
